bcd_timer_core: RTL and testbench

- Parametrised successor to the board's 4-digit stopwatch logic: N-digit BCD up/down timer with internal tick prescaler, run/pause state machine, lap capture with hold timeout, preset load, and countdown expiry.
- Sits between button/debounce logic and the seven-segment controllers.
- Outputs packed BCD for display plus status flags.

---
 rtl/bcd_timer_core_pkg.sv | 18 +
 rtl/bcd_timer_core_if.sv | 29 ++
 rtl/bcd_digit_updown.sv | 33 +++
 rtl/bcd_timer_core.sv | 143 ++++++++++++++
 tb/tb_bcd_timer_core.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_timer_core_pkg.sv
// Shared types and helpers for the BCD timer core: FSM state encoding,
// the largest legal BCD digit, and per-digit preset clamping.
package bcd_timer_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_timer_core_if.sv
// Control/status bundle between the button logic (master) and the
// timer core (slave).
interface bcd_timer_core_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  stop;
  logic                  lap;
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  mode_down;
  logic [4*DIGITS-1:0]   count_bcd;
  logic [4*DIGITS-1:0]   disp_bcd;
  logic                  running;
  logic                  lap_active;
  logic                  expired;
  logic                  tick;

  modport master (
    output start, stop, lap, clear, load, load_val, mode_down,
    input  count_bcd, disp_bcd, running, lap_active, expired, tick
  );

  modport slave (
    input  start, stop, lap, clear, load, load_val, mode_down,
    output count_bcd, disp_bcd, running, lap_active, expired, tick
  );
endinterface

// File: rtl/bcd_digit_updown.sv
// One BCD digit of an up/down counter chain; cin/cout carry the
// increment (dir=0) or borrow (dir=1) between neighbouring digits.
module bcd_digit_updown
  import bcd_timer_core_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       en,
  input  logic       dir,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);

  assign cout = en & cin & (dir ? (q == 4'd0) : (q == BCD_MAX));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (ld) begin
      q <= ld_val;
    end else if (en && cin) begin
      if (dir) q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
      else     q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_timer_core.sv
// N-digit BCD up/down timer: tick prescaler, run/pause FSM, lap capture
// with hold timer, preset load and countdown expiry.
module bcd_timer_core
  import bcd_timer_core_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int TICK_DIV  = 120000,
  parameter int LAP_TICKS = 200,
  parameter int WRAP      = 1
) (
  input logic             CLK,
  input logic             RST_N,
  bcd_timer_core_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV);

  state_t         state, state_nxt;
  logic           mode_r, mode_nxt;
  logic [PW-1:0]  pres;
  logic           tick_r;
  logic           expired_r, expire_nxt;
  logic [W-1:0]   count;
  logic [W-1:0]   ld_clamped;
  logic [W-1:0]   lap_reg;
  logic [7:0]     lap_timer;
  logic [DIGITS:0] carry;
  logic           step, do_load, do_clr;
  logic           at_zero, at_one, at_max;

  always_ff @(posedge CLK) begin
    if (!RST_N || bus.clear) begin
      pres   <= '0;
      tick_r <= 1'b0;
    end else if (pres == PW'(TICK_DIV - 1)) begin
      pres   <= '0;
      tick_r <= 1'b1;
    end else begin
      pres   <= pres + PW'(1);
      tick_r <= 1'b0;
    end
  end

  always_comb begin
    ld_clamped = '0;
    for (int i = 0; i < DIGITS; i++)
      ld_clamped[4*i +: 4] = clamp_digit(bus.load_val[4*i +: 4]);
  end

  assign at_zero = (count == '0);
  assign at_one  = (count == W'(1));
  assign at_max  = (count == {DIGITS{BCD_MAX}});

  // clear > load > stop > start; a countdown reaching zero overrides stop
  always_comb begin
    state_nxt  = state;
    mode_nxt   = mode_r;
    step       = 1'b0;
    do_load    = 1'b0;
    do_clr     = 1'b0;
    expire_nxt = 1'b0;
    if (bus.clear) begin
      do_clr    = 1'b1;
      state_nxt = ST_IDLE;
    end else begin
      if (state == ST_RUN && tick_r) begin
        if (mode_r) begin
          if (!at_zero) begin
            step = 1'b1;
            if (at_one) begin
              state_nxt  = ST_EXPIRED;
              expire_nxt = 1'b1;
            end
          end
        end else if (!at_max || WRAP != 0) begin
          step = 1'b1;
        end
      end
      if (bus.load && state != ST_RUN) begin
        do_load   = 1'b1;
        state_nxt = (ld_clamped == '0) ? ST_IDLE : ST_PAUSED;
      end else if (bus.stop) begin
        if (state == ST_RUN && !expire_nxt) state_nxt = ST_PAUSED;
      end else if (bus.start && (state == ST_IDLE || state == ST_PAUSED)
                   && !(bus.mode_down && at_zero)) begin
        state_nxt = ST_RUN;
        mode_nxt  = bus.mode_down;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      mode_r    <= 1'b0;
      expired_r <= 1'b0;
    end else begin
      state     <= state_nxt;
      mode_r    <= mode_nxt;
      expired_r <= expire_nxt;
    end
  end

  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_updown u_digit (
      .clk    (CLK),
      .rst_n  (RST_N),
      .clr    (do_clr),
      .ld     (do_load),
      .ld_val (ld_clamped[4*g +: 4]),
      .en     (step),
      .dir    (mode_r),
      .cin    (carry[g]),
      .q      (count[4*g +: 4]),
      .cout   (carry[g+1])
    );
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      lap_reg   <= '0;
      lap_timer <= 8'd0;
    end else if (bus.clear) begin
      lap_timer <= 8'd0;
    end else if (bus.lap && state != ST_IDLE) begin
      lap_reg   <= count;
      lap_timer <= 8'(LAP_TICKS);
    end else if (tick_r && lap_timer != 8'd0) begin
      lap_timer <= lap_timer - 8'd1;
    end
  end

  assign bus.count_bcd  = count;
  assign bus.running    = (state == ST_RUN);
  assign bus.lap_active = (lap_timer != 8'd0);
  assign bus.disp_bcd   = (lap_timer != 8'd0) ? lap_reg : count;
  assign bus.expired    = expired_r;
  assign bus.tick       = tick_r;

endmodule

// File: tb/tb_bcd_timer_core.sv
// Directed bench for bcd_timer_core: wrapping DUT plus a saturating twin
// sharing the same stimulus.
module tb_bcd_timer_core;

  logic clk;
  logic RST_N;
  int   checks   = 0;
  int   failures = 0;

  bcd_timer_core_if #(.DIGITS(4)) bus ();
  bcd_timer_core_if #(.DIGITS(4)) bus_s ();

  assign bus_s.start     = bus.start;
  assign bus_s.stop      = bus.stop;
  assign bus_s.lap       = bus.lap;
  assign bus_s.clear     = bus.clear;
  assign bus_s.load      = bus.load;
  assign bus_s.load_val  = bus.load_val;
  assign bus_s.mode_down = bus.mode_down;

  bcd_timer_core #(.DIGITS(4), .TICK_DIV(4), .LAP_TICKS(3), .WRAP(1)) dut (
    .CLK (clk), .RST_N (RST_N), .bus (bus.slave)
  );

  bcd_timer_core #(.DIGITS(4), .TICK_DIV(4), .LAP_TICKS(3), .WRAP(0)) dut_sat (
    .CLK (clk), .RST_N (RST_N), .bus (bus_s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    while (bus.tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.tick), 32'd1);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    int n;
    RST_N         = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.lap       = 1'b0;
    bus.clear     = 1'b0;
    bus.load      = 1'b0;
    bus.load_val  = 16'h0000;
    bus.mode_down = 1'b0;
    repeat (3) nxt();
    check("rst_count",   32'(bus.count_bcd), 32'h0);
    check("rst_disp",    32'(bus.disp_bcd),  32'h0);
    check("rst_running", 32'(bus.running),   32'd0);
    check("rst_lap",     32'(bus.lap_active), 32'd0);
    check("rst_expired", 32'(bus.expired),   32'd0);
    check("rst_tick",    32'(bus.tick),      32'd0);

    // up count: 10 ticks land within the 40 cycles after start
    RST_N = 1'b1;
    nxt();
    bus.start = 1'b1;
    nxt();
    check("start_running", 32'(bus.running), 32'd1);
    bus.start = 1'b0;
    repeat (39) nxt();
    check("up_40cyc", 32'(bus.count_bcd), 32'h0010);

    wait_tick("period_first");
    nxt();
    check("tick_width", 32'(bus.tick), 32'd0);
    n = 1;
    while (bus.tick !== 1'b1 && n < 10) begin
      nxt();
      n++;
    end
    check("tick_period", 32'(n), 32'd4);
    bus.stop = 1'b1;
    nxt();
    check("stop_running", 32'(bus.running), 32'd0);
    bus.stop = 1'b0;

    // BCD carry ripple, load ignored in RUN, wrap vs saturate
    bus.clear = 1'b1;
    nxt();
    check("clear_count", 32'(bus.count_bcd), 32'h0);
    bus.clear    = 1'b0;
    bus.load     = 1'b1;
    bus.load_val = 16'h0999;
    nxt();
    check("load_0999", 32'(bus.count_bcd), 32'h0999);
    check("load_paused", 32'(bus.running), 32'd0);
    bus.load  = 1'b0;
    bus.start = 1'b1;
    nxt();
    bus.start = 1'b0;
    wait_tick("tick_0999");
    nxt();
    check("ripple_1000", 32'(bus.count_bcd), 32'h1000);
    bus.load     = 1'b1;
    bus.load_val = 16'h5555;
    nxt();
    check("load_in_run", 32'(bus.count_bcd), 32'h1000);
    bus.load = 1'b0;
    bus.stop = 1'b1;
    nxt();
    bus.stop     = 1'b0;
    bus.load     = 1'b1;
    bus.load_val = 16'h9999;
    nxt();
    check("load_9999", 32'(bus.count_bcd), 32'h9999);
    bus.load  = 1'b0;
    bus.start = 1'b1;
    nxt();
    bus.start = 1'b0;
    wait_tick("tick_9999");
    nxt();
    check("wrap_0000", 32'(bus.count_bcd), 32'h0000);
    check("sat_9999",  32'(bus_s.count_bcd), 32'h9999);
    check("sat_running", 32'(bus_s.running), 32'd1);
    bus.stop = 1'b1;
    nxt();
    bus.stop = 1'b0;

    // countdown to expiry
    bus.load     = 1'b1;
    bus.load_val = 16'h0002;
    nxt();
    bus.load      = 1'b0;
    bus.mode_down = 1'b1;
    bus.start     = 1'b1;
    nxt();
    bus.start = 1'b0;
    wait_tick("tick_down1");
    nxt();
    check("down_0001", 32'(bus.count_bcd), 32'h0001);
    check("no_expired_early", 32'(bus.expired), 32'd0);
    wait_tick("tick_down2");
    nxt();
    check("down_0000", 32'(bus.count_bcd), 32'h0000);
    check("expired_pulse", 32'(bus.expired), 32'd1);
    check("expired_state", 32'(bus.running), 32'd0);
    bus.start = 1'b1;
    nxt();
    check("expired_width", 32'(bus.expired), 32'd0);
    nxt();
    check("start_in_expired", 32'(bus.running), 32'd0);
    check("expired_hold", 32'(bus.count_bcd), 32'h0000);
    bus.start = 1'b0;
    bus.clear = 1'b1;
    nxt();
    bus.clear = 1'b0;
    bus.start = 1'b1;
    nxt();
    check("start_down_zero", 32'(bus.running), 32'd0);
    bus.start     = 1'b0;
    bus.mode_down = 1'b0;

    // lap hold over three ticks with a known prescaler phase
    bus.clear = 1'b1;
    nxt();
    bus.clear    = 1'b0;
    bus.load     = 1'b1;
    bus.load_val = 16'h0042;
    nxt();
    bus.load  = 1'b0;
    bus.start = 1'b1;
    nxt();
    check("lap_run", 32'(bus.running), 32'd1);
    bus.start = 1'b0;
    bus.lap   = 1'b1;
    nxt();
    bus.lap = 1'b0;
    check("lap_disp0",   32'(bus.disp_bcd),   32'h0042);
    check("lap_active0", 32'(bus.lap_active), 32'd1);
    wait_tick("tick_lap1");
    nxt();
    check("lap_count1", 32'(bus.count_bcd), 32'h0043);
    check("lap_disp1",  32'(bus.disp_bcd),  32'h0042);
    wait_tick("tick_lap2");
    nxt();
    check("lap_count2",  32'(bus.count_bcd),  32'h0044);
    check("lap_disp2",   32'(bus.disp_bcd),   32'h0042);
    check("lap_active2", 32'(bus.lap_active), 32'd1);
    wait_tick("tick_lap3");
    nxt();
    check("lap_active3", 32'(bus.lap_active), 32'd0);
    check("lap_disp3",   32'(bus.disp_bcd),   32'h0045);

    // same-cycle priorities and preset clamping
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    nxt();
    check("start_stop", 32'(bus.running), 32'd0);
    check("start_stop_count", 32'(bus.count_bcd), 32'h0045);
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.clear    = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 16'h1234;
    nxt();
    check("clear_load", 32'(bus.count_bcd), 32'h0000);
    bus.clear    = 1'b0;
    bus.load_val = 16'hFA3C;
    nxt();
    check("clamp_load", 32'(bus.count_bcd), 32'h9939);
    bus.load = 1'b0;

    // reset while running with the lap hold active
    bus.start = 1'b1;
    bus.lap   = 1'b1;
    nxt();
    check("pre_rst_running", 32'(bus.running),    32'd1);
    check("pre_rst_lap",     32'(bus.lap_active), 32'd1);
    check("pre_rst_disp",    32'(bus.disp_bcd),   32'h9939);
    bus.start = 1'b0;
    bus.lap   = 1'b0;
    RST_N     = 1'b0;
    nxt();
    check("mid_rst_count",   32'(bus.count_bcd),  32'h0);
    check("mid_rst_disp",    32'(bus.disp_bcd),   32'h0);
    check("mid_rst_running", 32'(bus.running),    32'd0);
    check("mid_rst_lap",     32'(bus.lap_active), 32'd0);
    check("mid_rst_expired", 32'(bus.expired),    32'd0);
    check("mid_rst_tick",    32'(bus.tick),       32'd0);
    RST_N = 1'b1;
    nxt();
    check("post_rst_expired", 32'(bus.expired), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
